// File: rtl/passcode_pkg.sv
// Shared definitions for the passcode lock controller.
//   state_t  : controller modes
//   KEY_*    : non-digit key codes from the keypad decoder
//   is_digit : true for key codes 0-9
package passcode_pkg;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    UNLOCKED,
    PROGRAM,
    LOCKOUT
  } state_t;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_E = 4'hE;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter used to time the lockout period.
//   clk, reset  : clock, asynchronous active-high reset (count -> 0)
//   load        : load load_value this cycle (has priority over counting)
//   load_value  : value to load
//   done        : count is zero
// The counter stops at zero.
module lockout_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/passcode_controller.sv
// Passcode lock controller: accumulates keypad digits, checks them against
// a stored code on Enter, unlocks or counts failures, enforces a timed
// lockout after MAX_TRIES consecutive failures, and lets the user program
// a new code while unlocked.
//   clk, reset   : clock, asynchronous active-high reset
//   key_valid    : one-cycle pulse, key holds a new press
//   key          : 0-9 digits, A program, C clear, E enter
//   unlocked     : in UNLOCKED or PROGRAM
//   programming  : in PROGRAM
//   alarm        : in LOCKOUT
//   entry_count  : digits buffered
//   fail_count   : consecutive failed checks
module passcode_controller
  import passcode_pkg::*;
#(
  parameter int unsigned             CODE_LEN     = 4,
  parameter int unsigned             MAX_TRIES    = 3,
  parameter int unsigned             LOCK_CYCLES  = 1000,
  parameter logic [CODE_LEN*4-1:0]   DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic       unlocked,
  output logic       programming,
  output logic       alarm,
  output logic [3:0] entry_count,
  output logic [3:0] fail_count
);

  localparam int unsigned     CW        = CODE_LEN * 4;
  localparam int unsigned     TW        = $clog2(LOCK_CYCLES + 1);
  localparam logic [3:0]      FULL      = 4'(CODE_LEN);
  localparam logic [3:0]      MAX_FAIL  = 4'(MAX_TRIES);
  localparam logic [TW-1:0]   LOAD_VAL  = TW'(LOCK_CYCLES - 1);

  state_t          state, state_n;
  logic [CW-1:0]   buffer, buffer_n;
  logic [CW-1:0]   code, code_n;
  logic [3:0]      count_n, fail_n;
  logic [3:0]      fail_inc;
  logic            full;
  logic            timer_load;
  logic            timer_done;

  lockout_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (LOAD_VAL),
    .done       (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ENTRY;
      buffer      <= '0;
      code        <= DEFAULT_CODE;
      entry_count <= '0;
      fail_count  <= '0;
    end else begin
      state       <= state_n;
      buffer      <= buffer_n;
      code        <= code_n;
      entry_count <= count_n;
      fail_count  <= fail_n;
    end
  end

  assign full     = (entry_count == FULL);
  assign fail_inc = fail_count + 4'd1;

  always_comb begin
    state_n    = state;
    buffer_n   = buffer;
    code_n     = code;
    count_n    = entry_count;
    fail_n     = fail_count;
    timer_load = 1'b0;

    case (state)
      ENTRY: begin
        if (key_valid) begin
          if (is_digit(key)) begin
            if (!full) begin
              // Shift in at the LS nibble; the cast drops the oldest nibble.
              buffer_n = CW'({buffer, key});
              count_n  = entry_count + 4'd1;
            end
          end else if (key == KEY_C) begin
            buffer_n = '0;
            count_n  = '0;
          end else if (key == KEY_E) begin
            state_n = CHECK;
          end
        end
      end

      CHECK: begin
        buffer_n = '0;
        count_n  = '0;
        if (full && (buffer == code)) begin
          state_n = UNLOCKED;
          fail_n  = '0;
        end else if (fail_inc >= MAX_FAIL) begin
          state_n    = LOCKOUT;
          fail_n     = MAX_FAIL;
          timer_load = 1'b1;
        end else begin
          state_n = ENTRY;
          fail_n  = fail_inc;
        end
      end

      UNLOCKED: begin
        if (key_valid) begin
          if (key == KEY_C) begin
            state_n = ENTRY;
          end else if (key == KEY_A) begin
            state_n  = PROGRAM;
            buffer_n = '0;
            count_n  = '0;
          end
        end
      end

      PROGRAM: begin
        if (key_valid) begin
          if (is_digit(key)) begin
            if (!full) begin
              buffer_n = CW'({buffer, key});
              count_n  = entry_count + 4'd1;
            end
          end else if (key == KEY_C) begin
            state_n  = UNLOCKED;
            buffer_n = '0;
            count_n  = '0;
          end else if (key == KEY_E) begin
            buffer_n = '0;
            count_n  = '0;
            if (full) begin
              code_n  = buffer;
              state_n = ENTRY;
            end else begin
              state_n = UNLOCKED;
            end
          end
        end
      end

      LOCKOUT: begin
        if (timer_done) begin
          state_n = ENTRY;
          fail_n  = '0;
        end
      end

      default: state_n = ENTRY;
    endcase
  end

  assign unlocked    = (state == UNLOCKED) || (state == PROGRAM);
  assign programming = (state == PROGRAM);
  assign alarm       = (state == LOCKOUT);

endmodule

// File: tb/tb_passcode_controller.sv
// Self-checking bench for passcode_controller: directed scenarios with
// literal expectations plus randomized key traffic, all checked every cycle
// against a behavioural model built from digit queues and counters.
module tb_passcode_controller;
  import passcode_pkg::*;

  localparam int CL = 4;
  localparam int MT = 3;
  localparam int LC = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key;
  logic       unlocked, programming, alarm;
  logic [3:0] entry_count, fail_count;

  always #5 clk = ~clk;

  passcode_controller #(
    .CODE_LEN     (CL),
    .MAX_TRIES    (MT),
    .LOCK_CYCLES  (LC),
    .DEFAULT_CODE (16'h1234)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key         (key),
    .unlocked    (unlocked),
    .programming (programming),
    .alarm       (alarm),
    .entry_count (entry_count),
    .fail_count  (fail_count)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int m_dq[$];       // digits typed so far
  int m_code[CL];    // stored code, first digit first
  bit m_pend;        // Enter accepted, verdict due next cycle
  bit m_unl, m_prog;
  int m_lock;        // alarm cycles remaining
  int m_fail;
  bit m_match;

  task automatic model_reset();
    m_dq.delete();
    m_code = '{1, 2, 3, 4};
    m_pend = 0; m_unl = 0; m_prog = 0; m_lock = 0; m_fail = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] k);
    if (m_pend) begin
      m_pend  = 0;
      m_match = (m_dq.size() == CL);
      if (m_match)
        for (int j = 0; j < CL; j++) if (m_dq[j] != m_code[j]) m_match = 0;
      m_dq.delete();
      if (m_match) begin
        m_unl = 1; m_fail = 0;
      end else begin
        if (m_fail < MT) m_fail++;
        if (m_fail == MT) m_lock = LC;
      end
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fail = 0;
    end else if (kv) begin
      if (m_prog) begin
        if (k <= 9) begin
          if (m_dq.size() < CL) m_dq.push_back(int'(k));
        end else if (k == KEY_C) begin
          m_prog = 0; m_dq.delete();
        end else if (k == KEY_E) begin
          m_prog = 0;
          if (m_dq.size() == CL) begin
            for (int j = 0; j < CL; j++) m_code[j] = m_dq[j];
            m_unl = 0;
          end
          m_dq.delete();
        end
      end else if (m_unl) begin
        if (k == KEY_C) m_unl = 0;
        else if (k == KEY_A) begin m_prog = 1; m_dq.delete(); end
      end else begin
        if (k <= 9) begin
          if (m_dq.size() < CL) m_dq.push_back(int'(k));
        end else if (k == KEY_C) m_dq.delete();
        else if (k == KEY_E) m_pend = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step(key_valid, key);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("m_unlocked",    int'(unlocked),    int'(m_unl));
      chk("m_programming", int'(programming), int'(m_prog));
      chk("m_alarm",       int'(alarm),       int'(m_lock > 0));
      chk("m_entry_count", int'(entry_count), m_dq.size());
      chk("m_fail_count",  int'(fail_count),  m_fail);
    end
  end

  // Length of the most recent complete alarm run.
  int run = 0, last_run = 0;
  initial forever begin
    @(negedge clk);
    if (alarm) run++;
    else if (run != 0) begin last_run = run; run = 0; end
  end

  // Global time bound.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got 1, expected 0");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [3:0] k, input int gap);
    @(negedge clk);
    key_valid = 1'b1; key = k;
    @(negedge clk);
    key_valid = 1'b0; key = 4'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int j = 3; j >= 0; j--) press(c[j*4 +: 4], 4);
    press(KEY_E, 4);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_unlocked"},    int'(unlocked),    0);
    chk({tag, "_programming"}, int'(programming), 0);
    chk({tag, "_alarm"},       int'(alarm),       0);
    chk({tag, "_entry_count"}, int'(entry_count), 0);
    chk({tag, "_fail_count"},  int'(fail_count),  0);
  endtask

  task automatic wait_alarm_clear();
    int n = 0;
    while (alarm && n < 2 * LC) begin @(negedge clk); n++; end
    chk("lockout_ends", int'(alarm), 0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key = 4'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    cmp_en = 1;

    // Correct code; unlock two cycles after the E pulse.
    for (int j = 1; j <= 4; j++) press(4'(j), 4);
    @(negedge clk); key_valid = 1'b1; key = KEY_E;
    @(negedge clk); key_valid = 1'b0;
    chk("unlock_t1", int'(unlocked), 0);
    @(negedge clk);
    chk("unlock_t2", int'(unlocked), 1);
    chk("unlock_fail", int'(fail_count), 0);
    chk("unlock_count", int'(entry_count), 0);

    // Relock, then short entry fails.
    press(KEY_C, 4);
    press(4'd1, 4); press(4'd2, 4); press(4'd3, 4); press(KEY_E, 4);
    chk("short_unlocked", int'(unlocked), 0);
    chk("short_fail", int'(fail_count), 1);

    // Clear fail count, then three wrong entries trigger lockout.
    enter_code(16'h1234);
    press(KEY_C, 4);
    for (int t = 0; t < 3; t++) enter_code(16'h9999);
    chk("lockout_alarm", int'(alarm), 1);
    chk("lockout_fail", int'(fail_count), 3);
    enter_code(16'h1234);   // ignored during lockout
    wait_alarm_clear();
    chk("lockout_len", last_run, LC);
    chk("post_lock_fail", int'(fail_count), 0);
    chk("post_lock_unlocked", int'(unlocked), 0);

    // C clears partial entry.
    press(4'd5, 4); press(4'd6, 4);
    chk("pre_c_count", int'(entry_count), 2);
    press(KEY_C, 4);
    chk("post_c_count", int'(entry_count), 0);
    enter_code(16'h1234);
    chk("c_then_unlock", int'(unlocked), 1);

    // Program a new code.
    press(KEY_A, 4);
    chk("prog_on", int'(programming), 1);
    press(4'd9, 4); press(4'd8, 4); press(4'd7, 4); press(4'd6, 4);
    chk("prog_count", int'(entry_count), 4);
    press(KEY_E, 4);
    chk("prog_relock", int'(unlocked), 0);
    chk("prog_off", int'(programming), 0);
    enter_code(16'h1234);
    chk("old_code_fails", int'(unlocked), 0);
    chk("old_code_fail_cnt", int'(fail_count), 1);
    enter_code(16'h9876);
    chk("new_code_unlocks", int'(unlocked), 1);

    // Reset during PROGRAM restores defaults.
    press(KEY_A, 4); press(4'd9, 4); press(4'd8, 4);
    @(negedge clk); reset = 1'b1; #1;
    check_all_zero("rst_prog");
    @(negedge clk); @(negedge clk); reset = 1'b0;
    enter_code(16'h1234);
    chk("rst_prog_unlock", int'(unlocked), 1);

    // Reset during LOCKOUT.
    press(KEY_C, 4);
    for (int t = 0; t < 3; t++) enter_code(16'h5555);
    repeat (50) @(negedge clk);
    chk("lock2_alarm", int'(alarm), 1);
    reset = 1'b1; #1;
    check_all_zero("rst_lock");
    @(negedge clk); @(negedge clk); reset = 1'b0;
    enter_code(16'h1234);
    chk("rst_lock_unlock", int'(unlocked), 1);

    // Randomized traffic, including back-to-back key bursts.
    for (int i = 0; i < 700; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r < 2) begin
        for (int j = 0; j < CL; j++) press(4'(m_code[j]), $urandom_range(1, 3));
        press(KEY_E, $urandom_range(1, 3));
      end else if (r == 2) begin
        press(KEY_A, $urandom_range(1, 3));
      end else if (r == 3) begin
        @(negedge clk);
        key_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
          key = 4'($urandom);
          @(negedge clk);
        end
        key_valid = 1'b0;
      end else begin
        press(4'($urandom_range(0, 15)), $urandom_range(1, 3));
      end
    end
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
